ddr_rx_word_aligner: RTL and testbench

Word aligner for a DDR serial input lane. It consumes the two registered bits that the iCE40UP DDR input pin cell delivers each fabric clock: the rising-edge sample and the falling-edge sample. It searches the bit stream for a programmable sync word, confirms alignment, and then emits parallel words with a valid strobe to the capture logic downstream. Both bit phases are handled, so alignment works at any bit offset.

---
 rtl/ddr_rx_word_aligner.sv | 182 ++++++++++++++++++
 tb/tb_ddr_rx_word_aligner.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rx_word_aligner.sv
// DDR lane word aligner: hunts a sync word in the two-bit-per-clock
// stream from the pin cell, confirms it, then emits aligned words.
module ddr_rx_word_aligner #(
  parameter int                WORD_W      = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD   = 8'hB8,
  parameter int                SYNC_REPEAT = 2,
  parameter int                MAX_GAP     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din0,
  input  logic              din1,
  input  logic              resync,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sync,
  output logic              locked,
  output logic              phase,
  output logic              lock_lost,
  output logic [7:0]        lock_loss_cnt
);

  localparam int HALF = WORD_W / 2;
  localparam int CW   = (HALF < 2) ? 1 : $clog2(HALF);
  localparam int GW   = (MAX_GAP < 2) ? 1 : $clog2(MAX_GAP + 1);

  localparam logic [CW-1:0] WLAST    = CW'(HALF - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((MAX_GAP == 0) ? 0 : MAX_GAP - 1);
  localparam logic [3:0]    REP      = 4'(SYNC_REPEAT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Only the bits that can still land in the next window are kept.
  logic [WORD_W-2:0] sr_q, sr_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [3:0]        mcnt_q, mcnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sync_q, out_sync_d;
  logic              phase_q, phase_d;
  logic              lock_lost_q, lock_lost_d;
  logic [7:0]        loss_cnt_q, loss_cnt_d;

  logic [WORD_W:0]   nsr;
  logic [WORD_W-1:0] w0;
  logic [WORD_W-1:0] w1;
  logic [WORD_W-1:0] word;
  logic              boundary;
  logic              hit0;
  logic              hit1;
  logic              word_sync;

  always_comb begin
    nsr       = {sr_q, din0, din1};
    w0        = nsr[WORD_W-1:0];
    w1        = nsr[WORD_W:1];
    word      = phase_q ? w1 : w0;
    boundary  = (wcnt_q == WLAST);
    hit0      = (w0 == SYNC_WORD);
    hit1      = (w1 == SYNC_WORD);
    word_sync = (word == SYNC_WORD);
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    wcnt_d      = wcnt_q;
    mcnt_d      = mcnt_q;
    gap_d       = gap_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_sync_d  = 1'b0;
    phase_d     = phase_q;
    lock_lost_d = 1'b0;
    loss_cnt_d  = loss_cnt_q;

    if (resync) begin
      state_d = HUNT;
      wcnt_d  = '0;
      mcnt_d  = '0;
      gap_d   = '0;
      if (en) begin
        sr_d = nsr[WORD_W-2:0];
      end
    end else if (en) begin
      sr_d   = nsr[WORD_W-2:0];
      wcnt_d = boundary ? '0 : wcnt_q + 1'b1;
      unique case (state_q)
        HUNT: begin
          if (hit0 || hit1) begin
            phase_d = !hit0;
            wcnt_d  = '0;
            mcnt_d  = 4'd1;
            gap_d   = '0;
            state_d = (SYNC_REPEAT == 1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (boundary) begin
            if (word_sync) begin
              mcnt_d = mcnt_q + 4'd1;
              if (mcnt_q + 4'd1 == REP) begin
                state_d = LOCKED;
                gap_d   = '0;
              end
            end else begin
              state_d = HUNT;
              mcnt_d  = '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (word_sync) begin
              gap_d       = '0;
              out_valid_d = 1'b1;
              out_data_d  = word;
              out_sync_d  = 1'b1;
            end else if (MAX_GAP != 0 && gap_q == GAP_LAST) begin
              state_d     = HUNT;
              gap_d       = '0;
              lock_lost_d = 1'b1;
              loss_cnt_d  = (loss_cnt_q == 8'hFF) ? loss_cnt_q
                                                  : loss_cnt_q + 8'd1;
            end else begin
              gap_d       = (gap_q == '1) ? gap_q : gap_q + 1'b1;
              out_valid_d = 1'b1;
              out_data_d  = word;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      sr_q        <= '0;
      wcnt_q      <= '0;
      mcnt_q      <= '0;
      gap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sync_q  <= 1'b0;
      phase_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      wcnt_q      <= wcnt_d;
      mcnt_q      <= mcnt_d;
      gap_q       <= gap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sync_q  <= out_sync_d;
      phase_q     <= phase_d;
      lock_lost_q <= lock_lost_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_sync      = out_sync_q;
  assign locked        = (state_q == LOCKED);
  assign phase         = phase_q;
  assign lock_lost     = lock_lost_q;
  assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_ddr_rx_word_aligner.sv
// Bench for ddr_rx_word_aligner: bit-stream reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_ddr_rx_word_aligner;

  localparam int         W   = 8;
  localparam logic [7:0] SW  = 8'hB8;
  localparam int         REP = 2;
  localparam int         MG  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       din0 = 1'b0;
  logic       din1 = 1'b0;
  logic       resync = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sync;
  logic       locked;
  logic       phase;
  logic       lock_lost;
  logic [7:0] lock_loss_cnt;

  ddr_rx_word_aligner #(
    .WORD_W(W), .SYNC_WORD(SW), .SYNC_REPEAT(REP), .MAX_GAP(MG)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .din0(din0), .din1(din1),
    .resync(resync), .out_data(out_data), .out_valid(out_valid),
    .out_sync(out_sync), .locked(locked), .phase(phase),
    .lock_lost(lock_lost), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: full received bit history, absolute index of the next
  // expected word end, and the mode (0 hunt, 1 confirm, 2 locked).
  bit         hist[$];
  int         m_mode, m_next, m_match, m_gap;
  logic [7:0] e_data;
  bit         e_valid, e_sync, e_lost, e_phase;
  int         e_cnt;
  bit         started = 1'b0;

  logic [7:0] log_d[$];
  bit         log_s[$];
  int         log_c[$];
  int         n_lost;
  bit         txq[$];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [7:0] word_at(int e);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[k] = hist[e-k];
    return w;
  endfunction

  always @(posedge clk) begin
    int n;
    logic [7:0] w;
    cyc++;
    e_valid = 0;
    e_sync  = 0;
    e_lost  = 0;
    if (rst) begin
      hist.delete();
      repeat (16) hist.push_back(1'b0);
      m_mode  = 0;
      m_match = 0;
      m_gap   = 0;
      e_data  = '0;
      e_phase = 0;
      e_cnt   = 0;
      started = 1;
    end else if (started) begin
      if (en) begin
        hist.push_back(din0);
        hist.push_back(din1);
      end
      n = hist.size();
      if (resync) begin
        m_mode = 0;
      end else if (en) begin
        if (m_mode == 0) begin
          if (word_at(n-1) == SW || word_at(n-2) == SW) begin
            e_phase = (word_at(n-1) != SW);
            m_next  = (e_phase ? n-2 : n-1) + W;
            m_match = 1;
            m_gap   = 0;
            m_mode  = (REP == 1) ? 2 : 1;
          end
        end else if (m_next <= n-1) begin
          w = word_at(m_next);
          m_next += W;
          if (m_mode == 1) begin
            if (w == SW) begin
              m_match++;
              if (m_match == REP) begin
                m_mode = 2;
                m_gap  = 0;
              end
            end else begin
              m_mode = 0;
            end
          end else begin
            if (w != SW) m_gap++;
            else m_gap = 0;
            if (w != SW && MG != 0 && m_gap == MG) begin
              m_mode = 0;
              e_lost = 1;
              if (e_cnt < 255) e_cnt++;
            end else begin
              e_valid = 1;
              e_data  = w;
              e_sync  = (w == SW);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_data", 32'(out_data), 32'(e_data));
      chk("out_sync", 32'(out_sync), 32'(e_sync));
      chk("locked", 32'(locked), 32'(m_mode == 2));
      chk("phase", 32'(phase), 32'(e_phase));
      chk("lock_lost", 32'(lock_lost), 32'(e_lost));
      chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(e_cnt));
      if (out_valid === 1'b1) begin
        log_d.push_back(out_data);
        log_s.push_back(out_sync);
        log_c.push_back(cyc);
      end
      if (lock_lost === 1'b1) n_lost++;
    end
  end

  task automatic drive(bit a, bit b, bit e, bit rs);
    din0   = a;
    din1   = b;
    en     = e;
    resync = rs;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask

  task automatic push_byte(logic [7:0] b);
    for (int i = 7; i >= 0; i--) txq.push_back(b[i]);
  endtask

  task automatic send(bit toggle, int rs_at);
    if (txq.size() % 2 != 0) txq.push_back(1'b0);
    for (int p = 0; p < txq.size() / 2; p++) begin
      drive(txq[2*p], txq[2*p+1], 1'b1, p == rs_at);
      if (toggle) drive(1'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    txq.delete();
  endtask

  task automatic send_rand();
    while (txq.size() >= 2) begin
      while ($urandom_range(3) == 0)
        drive(1'($urandom), 1'($urandom), 1'b0,
              $urandom_range(79) == 0);
      drive(txq[0], txq[1], 1'b1, $urandom_range(79) == 0);
      void'(txq.pop_front());
      void'(txq.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) drive(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", 32'(out_data), 0);
    chk("rst out_sync", 32'(out_sync), 0);
    chk("rst locked", 32'(locked), 0);
    chk("rst phase", 32'(phase), 0);
    chk("rst lock_lost", 32'(lock_lost), 0);
    chk("rst lock_loss_cnt", 32'(lock_loss_cnt), 0);
    rst = 1'b0;
    log_d.delete();
    log_s.delete();
    log_c.delete();
    n_lost = 0;
  endtask

  task automatic check_pair(string nm, int gap_cycles, bit ph);
    chk({nm, " count"}, 32'(log_d.size()), 2);
    if (log_d.size() == 2) begin
      chk({nm, " word0"}, 32'(log_d[0]), 32'h12);
      chk({nm, " sync0"}, 32'(log_s[0]), 0);
      chk({nm, " word1"}, 32'(log_d[1]), 32'h34);
      chk({nm, " spacing"}, 32'(log_c[1] - log_c[0]), 32'(gap_cycles));
    end
    chk({nm, " locked"}, 32'(locked), 1);
    chk({nm, " phase"}, 32'(phase), 32'(ph));
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    push_byte(8'hB8); push_byte(8'hB8);
    push_byte(8'h12); push_byte(8'h34);
    send(1'b0, -1);
    idle(3);
    check_pair("even", 4, 1'b0);

    do_reset();
    txq.push_back(1'b0);
    push_byte(8'hB8); push_byte(8'hB8);
    push_byte(8'h12); push_byte(8'h34);
    send(1'b0, -1);
    idle(3);
    check_pair("odd", 4, 1'b1);

    do_reset();
    push_byte(8'hB8); push_byte(8'h55);
    send(1'b0, -1);
    idle(3);
    chk("cfail count", 32'(log_d.size()), 0);
    chk("cfail locked", 32'(locked), 0);
    push_byte(8'hB8); push_byte(8'hB8); push_byte(8'h12);
    send(1'b0, -1);
    idle(3);
    chk("cfail relock count", 32'(log_d.size()), 1);
    if (log_d.size() == 1) chk("cfail relock word", 32'(log_d[0]), 32'h12);

    do_reset();
    push_byte(8'hB8); push_byte(8'hB8);
    push_byte(8'h01); push_byte(8'h02);
    push_byte(8'h03); push_byte(8'h04);
    send(1'b0, -1);
    idle(3);
    chk("gap count", 32'(log_d.size()), 3);
    if (log_d.size() == 3) begin
      chk("gap word0", 32'(log_d[0]), 32'h01);
      chk("gap word1", 32'(log_d[1]), 32'h02);
      chk("gap word2", 32'(log_d[2]), 32'h03);
    end
    chk("gap lost pulses", 32'(n_lost), 1);
    chk("gap loss cnt", 32'(lock_loss_cnt), 1);
    chk("gap locked", 32'(locked), 0);

    log_d.delete();
    push_byte(8'hB8); push_byte(8'hB8); push_byte(8'h12);
    send(1'b0, 11);
    chk("resync locked", 32'(locked), 0);
    idle(3);
    chk("resync count", 32'(log_d.size()), 0);
    chk("resync loss cnt", 32'(lock_loss_cnt), 1);

    do_reset();
    push_byte(8'hB8); push_byte(8'hB8);
    push_byte(8'h12); push_byte(8'h34);
    send(1'b1, -1);
    idle(3);
    check_pair("en toggle", 8, 1'b0);

    do_reset();
    for (int c = 0; c < 500; c++) begin
      int r;
      r = $urandom_range(9);
      if (r < 4) push_byte(SW);
      else if (r < 9) push_byte(8'($urandom));
      else txq.push_back(1'($urandom));
      send_rand();
    end
    txq.delete();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
